counter_rf_block: RTL and testbench

- Register file with four 48-bit timestamp/event counters plus a software "rreinit" strobe register, on a simple read/write bus.
- Addressing is 8-byte-word aligned: only address bits [5:3] are decoded.
- Sits between a software register bus and hardware event sources.
  - Hardware drives count-up enables, and load strobes for tsc and tsc4.
  - Software reads all counters and can re-initialise tsc2/tsc3/tsc4.

---
 rtl/counter_rf_block.sv | 101 ++++++++++
 tb/tb_counter_rf_block.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_rf_block.sv
// Four 48-bit event/timestamp counters with a software register bus.
// Hardware loads and count-ups; software reads, writes tsc/tsc4 and re-inits tsc2..4.
module counter_rf_block (
  input  logic        clk,
  input  logic        res_n,
  input  logic [2:0]  address,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [47:0] write_data,
  output logic [47:0] read_data,
  output logic        invalid_address,
  output logic        access_complete,
  input  logic [47:0] tsc_cnt_next,
  input  logic        tsc_cnt_wen,
  input  logic        tsc_cnt_countup,
  output logic [47:0] tsc_cnt,
  input  logic        tsc2_cnt_countup,
  input  logic        tsc3_cnt_countup,
  input  logic [47:0] tsc4_cnt_next,
  input  logic        tsc4_cnt_wen,
  input  logic        tsc4_cnt_countup,
  output logic [47:0] tsc4_cnt
);

  localparam int DATA_W = 48;

  logic [DATA_W-1:0] tsc_q, tsc2_q, tsc3_q, tsc4_q;
  logic [DATA_W-1:0] rd_mux;
  logic              access, addr_bad, rreinit, wr_tsc, wr_tsc4;

  always_comb begin
    access   = read_en | write_en;
    addr_bad = (address > 3'd4);
    rreinit  = write_en && (address == 3'd1);
    wr_tsc   = write_en && (address == 3'd0);
    wr_tsc4  = write_en && (address == 3'd4);
  end

  // Read mux sees the counters before this edge's update.
  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux = tsc_q;
      3'd2:    rd_mux = tsc2_q;
      3'd3:    rd_mux = tsc3_q;
      3'd4:    rd_mux = tsc4_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res_n) begin
      tsc_q <= '0;
    end else if (tsc_cnt_wen) begin
      tsc_q <= tsc_cnt_next;
    end else if (wr_tsc) begin
      tsc_q <= write_data;
    end else if (tsc_cnt_countup) begin
      tsc_q <= tsc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res_n || rreinit) begin
      tsc2_q <= '0;
      tsc3_q <= '0;
    end else begin
      if (tsc2_cnt_countup) tsc2_q <= tsc2_q + 1'b1;
      if (tsc3_cnt_countup) tsc3_q <= tsc3_q + 1'b1;
    end
  end

  // Re-init beats the hardware load on tsc4.
  always_ff @(posedge clk) begin
    if (res_n || rreinit) begin
      tsc4_q <= '0;
    end else if (tsc4_cnt_wen) begin
      tsc4_q <= tsc4_cnt_next;
    end else if (wr_tsc4) begin
      tsc4_q <= write_data;
    end else if (tsc4_cnt_countup) begin
      tsc4_q <= tsc4_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res_n) begin
      read_data       <= '0;
      access_complete <= 1'b0;
      invalid_address <= 1'b0;
    end else begin
      if (read_en) read_data <= rd_mux;
      access_complete <= access;
      invalid_address <= access && addr_bad;
    end
  end

  assign tsc_cnt  = tsc_q;
  assign tsc4_cnt = tsc4_q;

endmodule

// File: tb/tb_counter_rf_block.sv
// Scoreboard bench for counter_rf_block: read expectations are queued when the
// read is issued and popped when access_complete returns.
module tb_counter_rf_block;

  logic        clk = 1'b0;
  logic        res_n = 1'b1;
  logic [2:0]  address = '0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [47:0] write_data = '0;
  logic [47:0] read_data;
  logic        invalid_address;
  logic        access_complete;
  logic [47:0] tsc_cnt_next = '0;
  logic        tsc_cnt_wen = 1'b0;
  logic        tsc_cnt_countup = 1'b0;
  logic [47:0] tsc_cnt;
  logic        tsc2_cnt_countup = 1'b0;
  logic        tsc3_cnt_countup = 1'b0;
  logic [47:0] tsc4_cnt_next = '0;
  logic        tsc4_cnt_wen = 1'b0;
  logic        tsc4_cnt_countup = 1'b0;
  logic [47:0] tsc4_cnt;

  logic [47:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  counter_rf_block dut (
    .clk(clk), .res_n(res_n), .address(address), .read_en(read_en),
    .write_en(write_en), .write_data(write_data), .read_data(read_data),
    .invalid_address(invalid_address), .access_complete(access_complete),
    .tsc_cnt_next(tsc_cnt_next), .tsc_cnt_wen(tsc_cnt_wen),
    .tsc_cnt_countup(tsc_cnt_countup), .tsc_cnt(tsc_cnt),
    .tsc2_cnt_countup(tsc2_cnt_countup), .tsc3_cnt_countup(tsc3_cnt_countup),
    .tsc4_cnt_next(tsc4_cnt_next), .tsc4_cnt_wen(tsc4_cnt_wen),
    .tsc4_cnt_countup(tsc4_cnt_countup), .tsc4_cnt(tsc4_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_countup(input logic v);
    tsc_cnt_countup  = v;
    tsc2_cnt_countup = v;
    tsc3_cnt_countup = v;
    tsc4_cnt_countup = v;
  endtask

  // Issue one read cycle (read_en left high) and score the returned data.
  task automatic do_read(input logic [2:0] a, input logic [47:0] exp, input string name);
    int n;
    logic [47:0] e;
    address = a;
    read_en = 1'b1;
    exp_q.push_back(exp);
    step();
    n = 0;
    while (!access_complete && n < 4) begin
      step();
      n++;
    end
    checks++;
    if (!access_complete) begin
      failures++;
      $display("FAIL %s timeout: access_complete never seen", name);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if (read_data !== e) begin
        failures++;
        $display("FAIL %s: read_data=%0d expected=%0d", name, read_data, e);
      end
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [47:0] d, input string name);
    address    = a;
    write_data = d;
    write_en   = 1'b1;
    step();
    write_en = 1'b0;
    checks++;
    if (access_complete !== 1'b1) begin
      failures++;
      $display("FAIL %s complete: got=%b expected=1", name, access_complete);
    end
  endtask

  task automatic test_reset();
    res_n = 1'b1;
    step();
    step();
    checks++;
    if (tsc_cnt !== 48'd0 || tsc4_cnt !== 48'd0) begin
      failures++;
      $display("FAIL reset_cnt: tsc=%0d tsc4=%0d expected 0", tsc_cnt, tsc4_cnt);
    end
    checks++;
    if (read_data !== 48'd0 || access_complete !== 1'b0 || invalid_address !== 1'b0) begin
      failures++;
      $display("FAIL reset_bus: rd=%0d ac=%b inv=%b expected 0/0/0",
               read_data, access_complete, invalid_address);
    end
    res_n = 1'b0;
  endtask

  task automatic test_count();
    set_countup(1'b1);
    for (int i = 0; i < 200; i++) begin
      checks++;
      if (tsc_cnt !== 48'(i) || tsc4_cnt !== 48'(i)) begin
        failures++;
        $display("FAIL count[%0d]: tsc=%0d tsc4=%0d expected=%0d", i, tsc_cnt, tsc4_cnt, i);
      end
      if (i == 199) set_countup(1'b0);
      step();
    end
    step();
    checks++;
    if (tsc_cnt !== 48'd199 || tsc4_cnt !== 48'd199) begin
      failures++;
      $display("FAIL count_hold: tsc=%0d tsc4=%0d expected=199", tsc_cnt, tsc4_cnt);
    end
  endtask

  task automatic test_read_counters();
    do_read(3'd2, 48'd199, "read_tsc2");
    do_read(3'd3, 48'd199, "read_tsc3");
    do_read(3'd0, 48'd199, "read_tsc");
    do_read(3'd4, 48'd199, "read_tsc4");
    read_en = 1'b0;
    step();
    checks++;
    if (access_complete !== 1'b0 || read_data !== 48'd199) begin
      failures++;
      $display("FAIL read_idle: ac=%b rd=%0d expected 0/199", access_complete, read_data);
    end
  endtask

  task automatic test_load();
    tsc_cnt_next  = 48'd400;
    tsc4_cnt_next = 48'd400;
    tsc_cnt_wen   = 1'b1;
    tsc4_cnt_wen  = 1'b1;
    step();
    checks++;
    if (tsc_cnt !== 48'd400 || tsc4_cnt !== 48'd400) begin
      failures++;
      $display("FAIL load: tsc=%0d tsc4=%0d expected=400", tsc_cnt, tsc4_cnt);
    end
    tsc_cnt_countup  = 1'b1;
    tsc4_cnt_countup = 1'b1;
    step();
    checks++;
    if (tsc_cnt !== 48'd400 || tsc4_cnt !== 48'd400) begin
      failures++;
      $display("FAIL load_over_countup: tsc=%0d tsc4=%0d expected=400", tsc_cnt, tsc4_cnt);
    end
    tsc_cnt_wen  = 1'b0;
    tsc4_cnt_wen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      checks++;
      if (tsc_cnt !== 48'(400 + i) || tsc4_cnt !== 48'(400 + i)) begin
        failures++;
        $display("FAIL load_count[%0d]: tsc=%0d tsc4=%0d expected=%0d",
                 i, tsc_cnt, tsc4_cnt, 400 + i);
      end
      if (i == 199) set_countup(1'b0);
      step();
    end
  endtask

  task automatic test_rreinit();
    tsc4_cnt_next = 48'd123;
    tsc4_cnt_wen  = 1'b1;
    do_write(3'd1, 48'(64'($urandom)), "rreinit");
    tsc4_cnt_wen = 1'b0;
    checks++;
    if (tsc_cnt !== 48'd599 || tsc4_cnt !== 48'd0) begin
      failures++;
      $display("FAIL rreinit: tsc=%0d tsc4=%0d expected 599/0", tsc_cnt, tsc4_cnt);
    end
    do_read(3'd2, 48'd0, "rreinit_tsc2");
    do_read(3'd3, 48'd0, "rreinit_tsc3");
    do_read(3'd1, 48'd0, "read_rreinit");
    do_read(3'd0, 48'd599, "rreinit_tsc");
    read_en = 1'b0;
    step();
  endtask

  task automatic test_invalid();
    address = 3'd6;
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    checks++;
    if (invalid_address !== 1'b1 || access_complete !== 1'b1 || read_data !== 48'd0) begin
      failures++;
      $display("FAIL invalid_read: inv=%b ac=%b rd=%0d expected 1/1/0",
               invalid_address, access_complete, read_data);
    end
    step();
    checks++;
    if (invalid_address !== 1'b0 || access_complete !== 1'b0) begin
      failures++;
      $display("FAIL invalid_pulse: inv=%b ac=%b expected 0/0", invalid_address, access_complete);
    end
    do_write(3'd7, 48'd777, "invalid_write");
    checks++;
    if (invalid_address !== 1'b1 || tsc_cnt !== 48'd599 || tsc4_cnt !== 48'd0) begin
      failures++;
      $display("FAIL invalid_write_state: inv=%b tsc=%0d tsc4=%0d expected 1/599/0",
               invalid_address, tsc_cnt, tsc4_cnt);
    end
  endtask

  task automatic test_sw_write();
    logic [47:0] e;
    do_write(3'd0, 48'hFFFF_FFFF_FFFF, "write_tsc_max");
    checks++;
    if (tsc_cnt !== 48'hFFFF_FFFF_FFFF) begin
      failures++;
      $display("FAIL write_tsc_max: tsc=%h expected=ffffffffffff", tsc_cnt);
    end
    tsc_cnt_countup = 1'b1;
    step();
    tsc_cnt_countup = 1'b0;
    checks++;
    if (tsc_cnt !== 48'd0) begin
      failures++;
      $display("FAIL wrap: tsc=%0d expected=0", tsc_cnt);
    end
    tsc_cnt_countup = 1'b1;
    do_write(3'd0, 48'd1000, "write_over_countup");
    tsc_cnt_countup = 1'b0;
    checks++;
    if (tsc_cnt !== 48'd1000) begin
      failures++;
      $display("FAIL write_over_countup: tsc=%0d expected=1000", tsc_cnt);
    end
    tsc_cnt_next = 48'd7;
    tsc_cnt_wen  = 1'b1;
    do_write(3'd0, 48'd9, "load_over_write");
    tsc_cnt_wen = 1'b0;
    checks++;
    if (tsc_cnt !== 48'd7) begin
      failures++;
      $display("FAIL load_over_write: tsc=%0d expected=7", tsc_cnt);
    end
    do_write(3'd2, 48'd55, "write_ro_tsc2");
    do_read(3'd2, 48'd0, "ro_tsc2_unchanged");
    read_en = 1'b0;
    step();
    // Simultaneous read and write of tsc4: old value returned, new value stored.
    address    = 3'd4;
    write_data = 48'hABC;
    read_en    = 1'b1;
    write_en   = 1'b1;
    exp_q.push_back(48'd0);
    step();
    read_en  = 1'b0;
    write_en = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (access_complete !== 1'b1 || read_data !== e || tsc4_cnt !== 48'hABC) begin
      failures++;
      $display("FAIL rw_same: ac=%b rd=%0d tsc4=%h expected 1/%0d/abc",
               access_complete, read_data, tsc4_cnt, e);
    end
    step();
    checks++;
    if (access_complete !== 1'b0) begin
      failures++;
      $display("FAIL rw_single: ac=%b expected=0", access_complete);
    end
  endtask

  task automatic test_reset_midcount();
    set_countup(1'b1);
    step();
    step();
    step();
    res_n = 1'b1;
    step();
    checks++;
    if (tsc_cnt !== 48'd0 || tsc4_cnt !== 48'd0 || read_data !== 48'd0) begin
      failures++;
      $display("FAIL mid_reset: tsc=%0d tsc4=%0d rd=%0d expected 0/0/0",
               tsc_cnt, tsc4_cnt, read_data);
    end
    res_n = 1'b0;
    step();
    step();
    checks++;
    if (tsc_cnt !== 48'd2 || tsc4_cnt !== 48'd2) begin
      failures++;
      $display("FAIL resume: tsc=%0d tsc4=%0d expected=2", tsc_cnt, tsc4_cnt);
    end
    do_read(3'd2, 48'd2, "resume_tsc2");
    read_en = 1'b0;
    set_countup(1'b0);
    step();
  endtask

  initial begin
    test_reset();
    test_count();
    test_read_counters();
    test_load();
    test_rreinit();
    test_invalid();
    test_sw_write();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
